// File: rtl/comp12_minmax_tracker_pkg.sv
// Shared definitions for the comp12 min/max tracker: sample width,
// default counter width and the frame FSM state encoding.
package comp12_minmax_tracker_pkg;

   localparam int SAMPLE_W      = 12;
   localparam int CNT_W_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACC    = 2'd1,
      REPORT = 2'd2
   } state_e;

endpackage

// File: rtl/comp12_minmax_tracker_comp12.sv
// comp12: 12-bit unsigned magnitude comparator.
// Exactly one of Fg (A > B), Fe (A == B), Fl (A < B) is high.
module comp12
   import comp12_minmax_tracker_pkg::*;
(
   input  logic [SAMPLE_W-1:0] A,
   input  logic [SAMPLE_W-1:0] B,
   output logic                Fg,
   output logic                Fe,
   output logic                Fl
);

   assign Fg = (A >  B);
   assign Fe = (A == B);
   assign Fl = (A <  B);

endmodule

// File: rtl/comp12_minmax_tracker.sv
// comp12_minmax_tracker: per-frame reduction of an unsigned 12-bit sample
// stream into max / index of first max / (optional) min / count / sat.
// Optional minimum tracking is built when the macro TRACK_MIN_EN is defined;
// otherwise m_min is tied to zero and no min hardware exists.
module comp12_minmax_tracker
   import comp12_minmax_tracker_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEFAULT
)
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [SAMPLE_W-1:0] s_data,
   input  logic                s_last,
   output logic                m_valid,
   input  logic                m_ready,
   output logic [SAMPLE_W-1:0] m_max,
   output logic [CNT_W-1:0]    m_max_idx,
   output logic [SAMPLE_W-1:0] m_min,
   output logic [CNT_W-1:0]    m_count,
   output logic                m_sat
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_e state_q, state_d;

   logic                s_accept;
   logic                m_xfer;
   logic                first;
   logic                frame_done;

   logic [SAMPLE_W-1:0] max_q, max_d;
   logic [CNT_W-1:0]    idx_q, idx_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                sat_q, sat_d;

   logic [SAMPLE_W-1:0] m_max_q;
   logic [CNT_W-1:0]    m_idx_q;
   logic [CNT_W-1:0]    m_cnt_q;
   logic                m_sat_q;

   logic                max_gt, max_eq, max_lt;

   assign s_accept   = s_valid && s_ready;
   assign m_xfer     = m_valid && m_ready;
   assign first      = (state_q == IDLE);
   assign frame_done = s_accept && s_last && !clr;

   // Frame state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state: clr wins over any accept or output transfer
   always_comb begin
      state_d = state_q;
      if (clr) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE, ACC: if (s_accept) state_d = s_last ? REPORT : ACC;
            REPORT:    if (m_xfer)   state_d = IDLE;
            default:   state_d = IDLE;
         endcase
      end
   end

   // Handshake outputs depend on state only (no m_ready -> s_ready path)
   always_comb begin
      s_ready = (state_q != REPORT);
      m_valid = (state_q == REPORT);
   end

   comp12 u_cmp_max (
      .A  (s_data),
      .B  (max_q),
      .Fg (max_gt),
      .Fe (max_eq),
      .Fl (max_lt)
   );

   // Running max / first-max index / saturating count for the current frame
   always_comb begin
      max_d = max_q;
      idx_d = idx_q;
      cnt_d = cnt_q;
      sat_d = sat_q;
      if (clr) begin
         max_d = '0;
         idx_d = '0;
         cnt_d = '0;
         sat_d = 1'b0;
      end else if (s_accept) begin
         if (first) begin
            max_d = s_data;
            idx_d = '0;
            cnt_d = CNT_W'(1);
            sat_d = 1'b0;
         end else begin
            // Ties hold the stored max so the earliest index survives
            max_d = (max_eq || max_lt) ? max_q : s_data;
            idx_d = max_gt ? cnt_q : idx_q;
            if (cnt_q == CNT_MAX) sat_d = 1'b1;
            else                  cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Accumulator registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         max_q <= '0;
         idx_q <= '0;
         cnt_q <= '0;
         sat_q <= 1'b0;
      end else begin
         max_q <= max_d;
         idx_q <= idx_d;
         cnt_q <= cnt_d;
         sat_q <= sat_d;
      end
   end

   // Result record captured on the last-sample accept, held through REPORT
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_max_q <= '0;
         m_idx_q <= '0;
         m_cnt_q <= '0;
         m_sat_q <= 1'b0;
      end else if (frame_done) begin
         m_max_q <= max_d;
         m_idx_q <= idx_d;
         m_cnt_q <= cnt_d;
         m_sat_q <= sat_d;
      end
   end

   assign m_max     = m_max_q;
   assign m_max_idx = m_idx_q;
   assign m_count   = m_cnt_q;
   assign m_sat     = m_sat_q;

`ifdef TRACK_MIN_EN
   logic [SAMPLE_W-1:0] min_q, min_d;
   logic [SAMPLE_W-1:0] m_min_q;
   logic                min_gt, min_eq, min_lt;
   logic                unused_min_flags;

   comp12 u_cmp_min (
      .A  (s_data),
      .B  (min_q),
      .Fg (min_gt),
      .Fe (min_eq),
      .Fl (min_lt)
   );

   // Only "less than" moves the minimum; the other flags are not needed
   assign unused_min_flags = min_gt ^ min_eq;

   // Running min for the current frame
   always_comb begin
      min_d = min_q;
      if (clr)              min_d = '0;
      else if (s_accept)    min_d = (first || min_lt) ? s_data : min_q;
   end

   // Min accumulator and its result register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         min_q   <= '0;
         m_min_q <= '0;
      end else begin
         min_q <= min_d;
         if (frame_done) m_min_q <= min_d;
      end
   end

   assign m_min = m_min_q;
`else
   assign m_min = '0;
`endif

endmodule

// File: tb/tb_comp12_minmax_tracker.sv
// Self-checking bench for comp12_minmax_tracker (CNT_W = 4 so saturation
// is reachable quickly). Expected records are produced by a small frame
// model, queued when a frame is driven and popped when m_valid appears.
module tb_comp12_minmax_tracker;

   localparam int CW = 4;

   typedef struct packed {
      logic [11:0]   max;
      logic [CW-1:0] idx;
      logic [11:0]   min;
      logic [CW-1:0] cnt;
      logic          sat;
   } res_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clr = 1'b0;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [11:0]   s_data = '0;
   logic          s_last = 1'b0;
   logic          m_valid;
   logic          m_ready = 1'b1;
   logic [11:0]   m_max;
   logic [CW-1:0] m_max_idx;
   logic [11:0]   m_min;
   logic [CW-1:0] m_count;
   logic          m_sat;

   res_t  sb[$];
   logic [11:0] samp [0:31];
   int total = 0;
   int bad   = 0;

   comp12_minmax_tracker #(.CNT_W(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .s_last    (s_last),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_max     (m_max),
      .m_max_idx (m_max_idx),
      .m_min     (m_min),
      .m_count   (m_count),
      .m_sat     (m_sat)
   );

   always #5 clk = ~clk;

   function automatic res_t observed();
      res_t r;
      r.max = m_max;
      r.idx = m_max_idx;
      r.min = m_min;
      r.cnt = m_count;
      r.sat = m_sat;
      return r;
   endfunction

   // Drive one sample and wait (bounded) for it to be accepted.
   task automatic send_sample(input logic [11:0] d, input logic last, output int waited);
      s_valid = 1'b1;
      s_data  = d;
      s_last  = last;
      waited  = 0;
      while (s_ready !== 1'b1 && waited < 20) begin
         @(posedge clk); #1;
         waited++;
      end
      if (s_ready !== 1'b1) begin
         total++; bad++;
         $display("FAIL send_timeout s_ready=%b required=1", s_ready);
      end
      @(posedge clk); #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   // Model samp[0..n-1] as one frame, queue the expected record, drive it.
   task automatic send_frame(input int n);
      res_t e;
      int   w;
      e = '0;
      for (int i = 0; i < n; i++) begin
         if (i == 0) begin
            e.max = samp[i]; e.min = samp[i]; e.idx = '0; e.cnt = 1; e.sat = 1'b0;
         end else begin
            if (samp[i] > e.max) begin e.max = samp[i]; e.idx = e.cnt; end
            if (samp[i] < e.min) e.min = samp[i];
            if (e.cnt == {CW{1'b1}}) e.sat = 1'b1;
            else                     e.cnt = e.cnt + 1'b1;
         end
      end
`ifndef TRACK_MIN_EN
      e.min = 12'd0;
`endif
      sb.push_back(e);
      for (int i = 0; i < n; i++) send_sample(samp[i], (i == n - 1), w);
   endtask

   // Bounded wait for m_valid, returning the record on the outputs.
   task automatic wait_out(output res_t got, output int waited);
      waited = 0;
      while (m_valid !== 1'b1 && waited < 20) begin
         @(posedge clk); #1;
         waited++;
      end
      got = observed();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
         bad++; $display("FAIL reset_hs s_ready=%b m_valid=%b required 1/0", s_ready, m_valid);
      end
      total++;
      if (observed() !== res_t'(0)) begin
         bad++; $display("FAIL reset_rec got=%h required=0", observed());
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic(input string tag);
      res_t got, exp;
      int   w;
      m_ready = 1'b1;
      samp[0] = 12'd5; samp[1] = 12'd9; samp[2] = 12'd3; samp[3] = 12'd9; samp[4] = 12'd7;
      send_frame(5);
      wait_out(got, w);
      exp = sb.pop_front();
      total++;
      if (m_valid !== 1'b1 || w != 0) begin
         bad++; $display("FAIL %s_latency m_valid=%b waited=%0d required 1/0", tag, m_valid, w);
      end
      total++;
      if (got !== exp) begin
         bad++; $display("FAIL %s_rec got=%h required=%h", tag, got, exp);
      end
      @(posedge clk); #1;
      total++;
      if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
         bad++; $display("FAIL %s_one_cycle m_valid=%b s_ready=%b required 0/1", tag, m_valid, s_ready);
      end
   endtask

   task automatic test_single();
      res_t got, exp;
      int   w;
      m_ready = 1'b1;
      samp[0] = 12'hFFF;
      send_frame(1);
      wait_out(got, w);
      exp = sb.pop_front();
      total++;
      if (m_valid !== 1'b1 || got !== exp) begin
         bad++; $display("FAIL single_rec m_valid=%b got=%h required=%h", m_valid, got, exp);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      res_t got, exp, hold;
      int   w;
      m_ready = 1'b0;
      samp[0] = 12'd2; samp[1] = 12'd8; samp[2] = 12'd8; samp[3] = 12'd1;
      send_frame(4);
      wait_out(hold, w);
      exp = sb.pop_front();
      total++;
      if (m_valid !== 1'b1 || hold !== exp) begin
         bad++; $display("FAIL bp_rec m_valid=%b got=%h required=%h", m_valid, hold, exp);
      end
      s_valid = 1'b1; s_data = 12'h123; s_last = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         got = observed();
         total++;
         if (m_valid !== 1'b1 || s_ready !== 1'b0 || got !== exp) begin
            bad++;
            $display("FAIL bp_hold cyc=%0d m_valid=%b s_ready=%b got=%h required 1/0/%h",
                     c, m_valid, s_ready, got, exp);
         end
      end
      s_valid = 1'b0; s_last = 1'b0;
      m_ready = 1'b1;
      @(posedge clk); #1;
      total++;
      if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
         bad++; $display("FAIL bp_release m_valid=%b s_ready=%b required 0/1", m_valid, s_ready);
      end
      samp[0] = 12'd4;
      send_frame(1);
      wait_out(got, w);
      exp = sb.pop_front();
      total++;
      if (m_valid !== 1'b1 || w != 0 || got !== exp) begin
         bad++; $display("FAIL bp_next m_valid=%b waited=%0d got=%h required=%h", m_valid, w, got, exp);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_saturation();
      res_t got, exp;
      int   w;
      m_ready = 1'b1;
      for (int i = 0; i < 20; i++) samp[i] = 12'd1;
      samp[20] = 12'h800;
      send_frame(21);
      wait_out(got, w);
      exp = sb.pop_front();
      total++;
      if (m_valid !== 1'b1 || got !== exp) begin
         bad++; $display("FAIL sat_rec m_valid=%b got=%h required=%h", m_valid, got, exp);
      end
      total++;
      if (m_count !== 4'd15 || m_sat !== 1'b1 || m_max_idx !== 4'd15) begin
         bad++; $display("FAIL sat_fields cnt=%0d sat=%b idx=%0d required 15/1/15", m_count, m_sat, m_max_idx);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_clr();
      res_t got, exp;
      int   w;
      // clr together with the last-sample accept
      m_ready = 1'b1;
      send_sample(12'd4, 1'b0, w);
      s_valid = 1'b1; s_data = 12'd6; s_last = 1'b1; clr = 1'b1;
      @(posedge clk); #1;
      s_valid = 1'b0; s_last = 1'b0; clr = 1'b0;
      total++;
      if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
         bad++; $display("FAIL clr_last m_valid=%b s_ready=%b required 0/1", m_valid, s_ready);
      end
      samp[0] = 12'd2; samp[1] = 12'd5;
      send_frame(2);
      wait_out(got, w);
      exp = sb.pop_front();
      total++;
      if (m_valid !== 1'b1 || got !== exp) begin
         bad++; $display("FAIL clr_last_next m_valid=%b got=%h required=%h", m_valid, got, exp);
      end
      @(posedge clk); #1;
      // clr during REPORT, colliding with an output transfer
      m_ready = 1'b0;
      samp[0] = 12'd7;
      send_frame(1);
      wait_out(got, w);
      exp = sb.pop_front();
      total++;
      if (m_valid !== 1'b1 || got !== exp) begin
         bad++; $display("FAIL clr_rep_pending m_valid=%b got=%h required=%h", m_valid, got, exp);
      end
      clr = 1'b1; m_ready = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      total++;
      if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
         bad++; $display("FAIL clr_report m_valid=%b s_ready=%b required 0/1", m_valid, s_ready);
      end
      samp[0] = 12'd1; samp[1] = 12'd1; samp[2] = 12'd1;
      send_frame(3);
      wait_out(got, w);
      exp = sb.pop_front();
      total++;
      if (m_valid !== 1'b1 || got !== exp) begin
         bad++; $display("FAIL clr_rep_next m_valid=%b got=%h required=%h", m_valid, got, exp);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_rst_mid();
      int w;
      m_ready = 1'b1;
      send_sample(12'd5, 1'b0, w);
      send_sample(12'd6, 1'b0, w);
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (s_ready !== 1'b1 || m_valid !== 1'b0 || observed() !== res_t'(0)) begin
         bad++;
         $display("FAIL rst_mid s_ready=%b m_valid=%b rec=%h required 1/0/0", s_ready, m_valid, observed());
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      test_basic("after_rst");
   endtask

   initial begin
      test_reset();
      test_basic("basic");
      test_single();
      test_backpressure();
      test_saturation();
      test_clr();
      test_rst_mid();
      total++;
      if (sb.size() != 0) begin
         bad++; $display("FAIL sb_drain left=%0d required=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
